// File: rtl/fluid_seq_pkg.sv
// Shared types and helpers for the fluid mix sequencer.
//   seq_state_t  : sequencer FSM states
//   MAX_CH       : upper bound on the number of inlet channels
//   POS_*        : phase positions; 0..MAX_CH-1 are inlets, then mix, flush, done
//   next_phase() : first non-zero phase at or after a given position
package fluid_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INLET,
    MIX,
    FLUSH,
    DONE
  } seq_state_t;

  localparam int MAX_CH = 8;

  localparam logic [3:0] POS_MIX   = 4'd8;
  localparam logic [3:0] POS_FLUSH = 4'd9;
  localparam logic [3:0] POS_DONE  = 4'd10;

  // Scans positions from from_pos upward and returns the first phase whose
  // count is non-zero; returns POS_DONE when nothing remains. nz_in must
  // already be masked to the channels that exist.
  function automatic logic [3:0] next_phase(
    input logic [3:0]        from_pos,
    input logic [MAX_CH-1:0] nz_in,
    input logic              nz_mix,
    input logic              nz_flush
  );
    logic [3:0] res;
    logic       found;
    res   = POS_DONE;
    found = 1'b0;
    for (int p = 0; p < MAX_CH; p++) begin
      if (!found && (4'(p) >= from_pos) && nz_in[p]) begin
        res   = 4'(p);
        found = 1'b1;
      end
    end
    if (!found && (from_pos <= POS_MIX) && nz_mix) begin
      res   = POS_MIX;
      found = 1'b1;
    end
    if (!found && (from_pos <= POS_FLUSH) && nz_flush) begin
      res = POS_FLUSH;
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase down-counter.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (takes priority over en)
//   load_val  : value loaded on phase entry (phase count minus one)
//   en        : decrement while non-zero
//   expired   : count has reached zero (last cycle of the phase)
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      // Holding at zero means the counter never wraps.
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/fluid_mix_sequencer.sv
// Timed valve sequencer: inlet 0..N_CH-1 dwell, mix, flush, done.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : sequence request, sampled only in IDLE
//   cfg_dwell  : per-inlet dwell counts, channel k at [k*CNT_W +: CNT_W]
//   cfg_mix    : mix valve open cycles
//   cfg_flush  : outlet valve open cycles
//   valve_in   : inlet valve enables (one-hot or zero)
//   valve_mix  : mix chamber valve enable
//   valve_out  : outlet/flush valve enable
//   busy       : sequence in progress, through the DONE cycle
//   done       : one-cycle end-of-sequence pulse
// Optional feature macro SEQ_ABORT_EN adds:
//   abort      : jump from inlet/mix straight to the full flush
//   aborted    : sticky flag, cleared by the next accepted start
module fluid_mix_sequencer
  import fluid_seq_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SEQ_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  input  logic                  start,
  input  logic [N_CH*CNT_W-1:0] cfg_dwell,
  input  logic [CNT_W-1:0]      cfg_mix,
  input  logic [CNT_W-1:0]      cfg_flush,
  output logic [N_CH-1:0]       valve_in,
  output logic                  valve_mix,
  output logic                  valve_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  seq_state_t            state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [N_CH*CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]      mix_q, mix_d;
  logic [CNT_W-1:0]      flush_q, flush_d;
  logic [N_CH-1:0]       valve_in_q, valve_in_d;
  logic                  valve_mix_q, valve_mix_d;
  logic                  valve_out_q, valve_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef SEQ_ABORT_EN
  logic                  aborted_q, aborted_d;
`endif

  // Counts used for the next-phase decision: live inputs while accepting a
  // start (the shadows load on that same edge), otherwise the shadows.
  logic [N_CH*CNT_W-1:0] src_dwell;
  logic [CNT_W-1:0]      src_mix, src_flush, sel_cnt;
  logic [MAX_CH-1:0]     nz_in;
  logic [3:0]            from_pos, tgt;
  logic                  take;
  logic                  timer_load, timer_en, timer_expired;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (sel_cnt - 1'b1),
    .en       (timer_en),
    .expired  (timer_expired)
  );

  // NOTE: every signal written here gets a default first, so no path
  // leaves a value held and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    dwell_d    = dwell_q;
    mix_d      = mix_q;
    flush_d    = flush_q;
    take       = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    sel_cnt    = '0;
    nz_in      = '0;
    valve_in_d = '0;
`ifdef SEQ_ABORT_EN
    aborted_d  = aborted_q;
`endif

    if (state_q == IDLE) begin
      src_dwell = cfg_dwell;
      src_mix   = cfg_mix;
      src_flush = cfg_flush;
    end else begin
      src_dwell = dwell_q;
      src_mix   = mix_q;
      src_flush = flush_q;
    end

    for (int k = 0; k < N_CH; k++) begin
      nz_in[k] = |src_dwell[k*CNT_W +: CNT_W];
    end

    case (state_q)
      IDLE:    from_pos = 4'd0;
      INLET:   from_pos = 4'(ch_q) + 4'd1;
      MIX:     from_pos = POS_FLUSH;
      default: from_pos = POS_DONE;
    endcase

    tgt = next_phase(from_pos, nz_in, |src_mix, |src_flush);

    case (state_q)
      IDLE: begin
        if (start) begin
          take    = 1'b1;
          dwell_d = cfg_dwell;
          mix_d   = cfg_mix;
          flush_d = cfg_flush;
`ifdef SEQ_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      INLET, MIX, FLUSH: begin
        timer_en = 1'b1;
        take     = timer_expired;
      end
      default: state_d = IDLE;
    endcase

`ifdef SEQ_ABORT_EN
    // Abort overrides the normal advance from inlet or mix only.
    if (abort && ((state_q == INLET) || (state_q == MIX))) begin
      take      = 1'b1;
      tgt       = (|flush_q) ? POS_FLUSH : POS_DONE;
      aborted_d = 1'b1;
    end
`endif

    if (tgt == POS_MIX) begin
      sel_cnt = src_mix;
    end else if (tgt == POS_FLUSH) begin
      sel_cnt = src_flush;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (tgt == 4'(k)) sel_cnt = src_dwell[k*CNT_W +: CNT_W];
      end
    end

    if (take) begin
      timer_load = (tgt != POS_DONE);
      if (tgt == POS_DONE)       state_d = DONE;
      else if (tgt == POS_FLUSH) state_d = FLUSH;
      else if (tgt == POS_MIX)   state_d = MIX;
      else begin
        state_d = INLET;
        ch_d    = tgt[CH_W-1:0];
      end
    end

    // Outputs are decoded from the next state and registered, so they
    // change on the same edge as the FSM with no combinational path out.
    for (int k = 0; k < N_CH; k++) begin
      valve_in_d[k] = (state_d == INLET) && (ch_d == CH_W'(k));
    end
    valve_mix_d = (state_d == MIX);
    valve_out_d = (state_d == FLUSH);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // NOTE: the configuration shadows are reset along with the FSM so a
  // sequence can never run on counts left over from before reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      dwell_q     <= '0;
      mix_q       <= '0;
      flush_q     <= '0;
      valve_in_q  <= '0;
      valve_mix_q <= 1'b0;
      valve_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dwell_q     <= dwell_d;
      mix_q       <= mix_d;
      flush_q     <= flush_d;
      valve_in_q  <= valve_in_d;
      valve_mix_q <= valve_mix_d;
      valve_out_q <= valve_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEQ_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign valve_in  = valve_in_q;
  assign valve_mix = valve_mix_q;
  assign valve_out = valve_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SEQ_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_fluid_mix_sequencer.sv
// Directed testbench for fluid_mix_sequencer (N_CH=3, CNT_W=16).
// Observed vector per cycle: {valve_in[2:0], valve_mix, valve_out, busy, done}.
// Cycle i counts clock edges after the edge that accepted start.
module tb_fluid_mix_sequencer;

  localparam int N_CH  = 3;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [N_CH*CNT_W-1:0] cfg_dwell = '0;
  logic [CNT_W-1:0]      cfg_mix = '0;
  logic [CNT_W-1:0]      cfg_flush = '0;
  logic [N_CH-1:0]       valve_in;
  logic                  valve_mix, valve_out, busy, done;
`ifdef SEQ_ABORT_EN
  logic                  abort = 1'b0;
  logic                  aborted;
`endif

  int checks   = 0;
  int failures = 0;

  logic [6:0] obs;
  assign obs = {valve_in, valve_mix, valve_out, busy, done};

  fluid_mix_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .start     (start),
    .cfg_dwell (cfg_dwell),
    .cfg_mix   (cfg_mix),
    .cfg_flush (cfg_flush),
    .valve_in  (valve_in),
    .valve_mix (valve_mix),
    .valve_out (valve_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Expected vector at cycle i for back-to-back phases of the given lengths.
  function automatic logic [6:0] exp_trace(int d0, int d1, int d2, int mx, int fl, int i);
    int e0, e1, e2, em, ef;
    logic [6:0] v;
    e0 = d0; e1 = e0 + d1; e2 = e1 + d2; em = e2 + mx; ef = em + fl;
    v = 7'b0;
    if (i >= 1 && i <= e0)                v[6:4] = 3'b001;
    else if (i > e0 && i <= e1)           v[6:4] = 3'b010;
    else if (i > e1 && i <= e2)           v[6:4] = 3'b100;
    else if (i > e2 && i <= em)           v[3]   = 1'b1;
    else if (i > em && i <= ef)           v[2]   = 1'b1;
    if (i >= 1 && i <= ef + 1)            v[1]   = 1'b1;
    if (i == ef + 1)                      v[0]   = 1'b1;
    return v;
  endfunction

  task automatic set_cfg(int d0, int d1, int d2, int mx, int fl);
    cfg_dwell = {CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    cfg_mix   = CNT_W'(mx);
    cfg_flush = CNT_W'(fl);
  endtask

  // Returns at the falling edge of cycle 1.
  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 7'b0);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected %b", obs, 7'b0);
    end
  endtask

  task automatic test_full_sequence();
    logic [6:0] e;
    set_cfg(4, 2, 3, 5, 2);
    start_pulse();
    for (int i = 1; i <= 19; i++) begin
      e = exp_trace(4, 2, 3, 5, 2, i);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL full_seq cycle %0d: got %b expected %b", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_skip_zero();
    logic [6:0] e;
    set_cfg(0, 3, 0, 0, 1);
    start_pulse();
    for (int i = 1; i <= 7; i++) begin
      e = exp_trace(0, 3, 0, 0, 1, i);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL skip_zero cycle %0d: got %b expected %b", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all_zero();
    logic [6:0] e;
    set_cfg(0, 0, 0, 0, 0);
    start_pulse();
    for (int i = 1; i <= 4; i++) begin
      e = (i == 1) ? 7'b0000011 : 7'b0;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL all_zero cycle %0d: got %b expected %b", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  // cfg change plus a second start during inlet ch1 must not disturb timing.
  task automatic test_busy_start_ignored();
    logic [6:0] e;
    set_cfg(4, 2, 3, 5, 2);
    start_pulse();
    for (int i = 1; i <= 20; i++) begin
      e = exp_trace(4, 2, 3, 5, 2, i);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL busy_start cycle %0d: got %b expected %b", i, obs, e);
      end
      if (i == 5) begin
        cfg_dwell = {16'd7, 16'd9, 16'd1};
        cfg_mix   = 16'd1;
        start     = 1'b1;
      end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mix();
    logic [6:0] e;
    set_cfg(4, 2, 3, 5, 2);
    start_pulse();
    for (int i = 1; i < 12; i++) @(negedge clk);
    checks++;
    if (obs !== 7'b0001010) begin
      failures++;
      $display("FAIL mid_mix_before_reset: got %b expected %b", obs, 7'b0001010);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %b expected %b", obs, 7'b0);
    end
    @(negedge clk) rst = 1'b0;
    start_pulse();
    for (int i = 1; i <= 18; i++) begin
      e = exp_trace(4, 2, 3, 5, 2, i);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL after_reset cycle %0d: got %b expected %b", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

`ifdef SEQ_ABORT_EN
  task automatic test_abort();
    logic [6:0] e;
    logic       ea;
    set_cfg(4, 2, 3, 5, 3);
    start_pulse();
    for (int i = 1; i <= 8; i++) begin
      if (i <= 2)      e = 7'b0010010;
      else if (i <= 5) e = 7'b0000110;
      else if (i == 6) e = 7'b0000011;
      else             e = 7'b0;
      ea = (i >= 3);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort cycle %0d: got %b expected %b", i, obs, e);
      end
      checks++;
      if (aborted !== ea) begin
        failures++;
        $display("FAIL aborted_flag cycle %0d: got %b expected %b", i, aborted, ea);
      end
      if (i == 2) abort = 1'b1;
      if (i == 3) abort = 1'b0;
      @(negedge clk);
    end
    set_cfg(0, 0, 0, 0, 0);
    start_pulse();
    checks++;
    if (aborted !== 1'b0 || obs !== 7'b0000011) begin
      failures++;
      $display("FAIL aborted_cleared: got aborted=%b obs=%b expected 0 %b", aborted, obs, 7'b0000011);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_sequence();
    test_skip_zero();
    test_all_zero();
    test_busy_start_ignored();
    test_reset_mid_mix();
`ifdef SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
